// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   div_state_t : divider FSM encoding (IDLE, CALC, DONE)
//   div_cnt_w() : bit width of the iteration counter for a given operand width
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 64;

  // Counter width; must hold WIDTH-1 (the first iteration index).
  function automatic int div_cnt_w(input int width);
    if (width <= 2) begin
      return 1;
    end else begin
      return $clog2(width);
    end
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (purely combinational).
//   rem      in  WIDTH  partial remainder before this step
//   msb      in  1      next dividend bit shifted into the remainder
//   b        in  WIDTH  divisor
//   rem_next out WIDTH  partial remainder after this step
//   q_bit    out 1      quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             msb,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] diff;

  // Trial subtraction: the WIDTH+1-bit compare gives the sign of
  // {rem, msb} - b; the low WIDTH bits of the difference are the new
  // remainder whenever the trial is non-negative.
  always_comb begin
    partial = {rem, msb};
    diff    = partial[WIDTH-1:0] - b;
    q_bit   = (partial >= {1'b0, b});
    if (q_bit) begin
      rem_next = diff;
    end else begin
      rem_next = partial[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/seq_divider64.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
//   Q = A / B, R = A % B, start/valid_out pulse handshake.
// Ports:
//   clk, rst_n (async active-low)
//   start         request, sampled only in IDLE
//   A, B          dividend / divisor, captured when start is accepted
//   Q, R          quotient / remainder, held until the next completion
//   valid_out     one-cycle pulse when Q/R/div_by_zero are new
//   busy          high while an operation is in CALC or DONE
//   div_by_zero   B was zero for the completed operation
// Configuration macro: DIV_FAST_SPECIAL_EN
//   When defined, B==0 and A<B are resolved at start acceptance and the
//   FSM goes straight to DONE. Results are identical in both builds.
module seq_divider64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             valid_out,
  output logic             busy,
  output logic             div_by_zero
);

  import div_pkg::*;

  localparam int CNT_W = div_cnt_w(WIDTH);

  div_state_t       state_q, state_d;
  // dvd_q holds the dividend in its upper bits and collects quotient bits
  // at the LSB; after WIDTH shifts it contains exactly the quotient.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .msb      (dvd_q[WIDTH-1]),
    .b        (b_q),
    .rem_next (step_rem),
    .q_bit    (step_qbit)
  );

  // Next-state and next-output computation for the divider FSM.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    q_d     = q_q;
    r_d     = r_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    dz_d    = dz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          b_d     = B;
          dvd_d   = A;
          rem_d   = {WIDTH{1'b0}};
          cnt_d   = CNT_W'(WIDTH - 1);
          dbz_d   = (B == {WIDTH{1'b0}});
          busy_d  = 1'b1;
          state_d = CALC;
`ifdef DIV_FAST_SPECIAL_EN
          // Preload the final working regs so DONE publishes them directly.
          if (B == {WIDTH{1'b0}}) begin
            dvd_d   = {WIDTH{1'b1}};
            rem_d   = A;
            state_d = DONE;
          end else if (A < B) begin
            dvd_d   = {WIDTH{1'b0}};
            rem_d   = A;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
`endif
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      CALC: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[WIDTH-2:0], step_qbit};
        if (cnt_q == {CNT_W{1'b0}}) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = CALC;
        end
      end

      DONE: begin
        q_d     = dvd_q;
        r_d     = rem_q;
        dz_d    = dbz_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, working and output registers; reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= {WIDTH{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      dbz_q   <= 1'b0;
      q_q     <= {WIDTH{1'b0}};
      r_q     <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
      q_q     <= q_d;
      r_q     <= r_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      dz_q    <= dz_d;
    end
  end

  assign Q           = q_q;
  assign R           = r_q;
  assign valid_out   = valid_q;
  assign busy        = busy_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_divider64.sv
// Self-checking bench for seq_divider64: scoreboard of expected results,
// directed corner cases, reset abort and random back-to-back operations.
module tb_seq_divider64;

  localparam int W = 64;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         valid_out;
  logic         busy;
  logic         div_by_zero;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_ops    = 0;
  int   n_valid  = 0;

  seq_divider64 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .A           (A),
    .B           (B),
    .Q           (Q),
    .R           (R),
    .valid_out   (valid_out),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_checks++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == 64'd0) begin
      e.q = {W{1'b1}};
      e.r = a;
      e.dbz = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard: every valid_out pops one expected result.
  always @(negedge clk) begin
    if (rst_n && valid_out) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        check("stray_valid", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("Q", Q, mon_e.q);
        check("R", R, mon_e.r);
        check("dbz", {63'd0, div_by_zero}, {63'd0, mon_e.dbz});
      end
    end
  end

  // Called at a negedge; runs one operation and checks busy and latency.
  // poke != 0 pulses start with A=B=1 after that many CALC edges.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int poke);
    int edges;
    int exp_lat;
    bit seen;
    exp_q.push_back(model(a, b));
    n_ops++;
    exp_lat = W + 1;
`ifdef DIV_FAST_SPECIAL_EN
    if (b == 64'd0 || a < b) exp_lat = 1;
`endif
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    A = ~a;
    B = ~b;
    check("busy_start", {63'd0, busy}, 64'd1);
    edges = 0;
    seen = 1'b0;
    while (!seen && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (poke != 0 && edges == poke) begin
        A = 64'd1;
        B = 64'd1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (valid_out) seen = 1'b1;
      else if (busy !== 1'b1) check("busy_calc", {63'd0, busy}, 64'd1);
    end
    start = 1'b0;
    if (!seen) check("timeout", 64'd0, 64'd1);
    else check("latency", 64'(edges), 64'(exp_lat));
    check("busy_done", {63'd0, busy}, 64'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_q"}, Q, 64'd0);
    check({tag, "_r"}, R, 64'd0);
    check({tag, "_flags"}, {61'd0, valid_out, busy, div_by_zero}, 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] ra, rb;
    rst_n = 1'b0;
    start = 1'b0;
    A = 64'd0;
    B = 64'd0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(64'd100, 64'd7, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0);
    run_op(64'h1234, 64'd0, 0);
    run_op(64'd0, 64'd5, 0);
    run_op(64'd5, 64'd9, 20);

    // Reset in the middle of CALC aborts with no valid_out
    A = 64'd1000;
    B = 64'd3;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("abort");
    repeat (3) @(negedge clk);
    check_zero_outputs("abort_hold");
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("post_reset_idle", {62'd0, valid_out, busy}, 64'd0);
    end
    run_op(64'd42, 64'd6, 0);

    // Random back-to-back operations
    for (int i = 0; i < 300; i++) begin
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: rb = {$urandom, $urandom};
        1: rb = 64'($urandom_range(1, 65535));
        2: rb = ra >> $urandom_range(0, 63);
        default: rb = ra + 64'($urandom_range(0, 1000));
      endcase
      if (rb == 64'd0) rb = 64'd1;
      run_op(ra, rb, 0);
    end

    repeat (3) @(negedge clk);
    check("valid_count", 64'(n_valid), 64'(n_ops));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
